// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with uart_tx), baud timing
// derivation and frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // 17 bits covers CLKS_PER_BIT at 1200 baud from a 100 MHz clock.
    localparam int CNT_W = 17;

    function automatic int clks_per_bit(input int clk_rate, input int uart_rate);
        return clk_rate / uart_rate;
    endfunction

    function automatic int half_bit(input int clk_rate, input int uart_rate);
        return clks_per_bit(clk_rate, uart_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin. With UART_RX_MAJORITY_EN defined the
// sample value is the 2-of-3 vote over the last three synchronized values.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_data_in,
    output logic rx_s,
    output logic rx_sample
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx_data_in};
    end

    // Reset to the idle-high line level so no false start follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q holds rx_s from one and two cycles ago; with rx_s it forms the
    // three-sample window voted on at each sample point.
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rx_sample = (hist_q[1] & hist_q[0]) |
                       (hist_q[1] & rx_s) |
                       (hist_q[0] & rx_s);
`else
    assign rx_sample = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, centre sampling. Optional 2-of-3 majority
// sampling is enabled with the UART_RX_MAJORITY_EN macro.
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_RATE = 115200,
    parameter int CLK_RATE  = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, UART_RATE);
    localparam int HALF_BIT     = half_bit(CLK_RATE, UART_RATE);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;
    logic rx_sample;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .rx_data_in (rx_data_in),
        .rx_s       (rx_s),
        .rx_sample  (rx_sample)
    );

    uart_state_e    state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_reg_q, shift_reg_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_frame_err_q, rx_frame_err_d;

    always_comb begin
        state_d        = state_q;
        clk_cnt_d      = clk_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_reg_d    = shift_reg_q;
        rx_byte_d      = rx_byte_q;
        rx_valid_d     = rx_valid_q;
        rx_frame_err_d = rx_frame_err_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_s == 1'b0) begin
                    state_d = START;
                end
            end

            // Half a bit in: a high line here means the falling edge was a glitch.
            START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    state_d   = rx_sample ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d              = '0;
                    shift_reg_d[bit_idx_q] = rx_sample;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    if (rx_sample) begin
                        rx_byte_d  = shift_reg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_frame_err_d = 1'b1;
                    end
                    state_d = CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            CLEANUP: begin
                rx_valid_d     = 1'b0;
                rx_frame_err_d = 1'b0;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            clk_cnt_q      <= '0;
            bit_idx_q      <= '0;
            shift_reg_q    <= '0;
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_reg_q    <= shift_reg_d;
            rx_byte_q      <= rx_byte_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frame stimulus for uart_rx, checked against an
// expected-byte queue and frame-error count.
module tb_uart_rx;

    localparam int CLK_RATE_TB  = 10000000;
    localparam int UART_RATE_TB = 115200;
    localparam int C   = CLK_RATE_TB / UART_RATE_TB;
    localparam int H   = C / 2;
    localparam int LAT = 3 + H + 9 * C;

    logic       clk;
    logic       rst;
    logic       rx_data_in;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_frame_err;

    uart_rx #(
        .UART_RATE (UART_RATE_TB),
        .CLK_RATE  (CLK_RATE_TB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_in   (rx_data_in),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_active    (rx_active),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         exp_err    = 0;
    int         exp_valid  = 0;
    logic [7:0] last_good  = 8'h00;

    int   n_valid        = 0;
    int   n_err          = 0;
    int   last_valid_cyc = 0;
    int   frame_e1       = 0;
    logic prev_valid     = 1'b0;
    logic prev_err       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int clks);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        frame_e1 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx_data_in = f[i];
            repeat (clks) @(negedge clk);
        end
        rx_data_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_data_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_good(input logic [7:0] b);
        exp_q.push_back(b);
        exp_valid++;
        last_good = b;
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
            check("valid_with_err", {31'd0, rx_frame_err}, 32'd0);
            check("valid_width", {31'd0, prev_valid}, 32'd0);
        end
        if (rx_frame_err) begin
            n_err++;
            check("err_width", {31'd0, prev_err}, 32'd0);
        end
        prev_valid = rx_valid;
        prev_err   = rx_frame_err;
    end

    initial begin
        logic [7:0] b;
        logic       is_bad;
        int         clks;
        int         gap;
        logic [9:0] f;

        rst        = 1'b1;
        rx_data_in = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_byte",   {24'd0, rx_byte}, 32'd0);
        check("reset_valid",  {31'd0, rx_valid}, 32'd0);
        check("reset_active", {31'd0, rx_active}, 32'd0);
        check("reset_err",    {31'd0, rx_frame_err}, 32'd0);
        rst = 1'b0;
        idle(10);
        check("idle_active", {31'd0, rx_active}, 32'd0);

        // Good frame, ideal timing, with latency and rx_active checks
        push_good(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, C);
            begin
                repeat (10) @(negedge clk);
                check("active_start", {31'd0, rx_active}, 32'd1);
                repeat (5 * C) @(negedge clk);
                check("active_data", {31'd0, rx_active}, 32'd1);
                repeat (4 * C) @(negedge clk);
                check("active_stop", {31'd0, rx_active}, 32'd1);
            end
        join
        idle(C);
        check("a5_count", 32'(n_valid), 32'd1);
        check("a5_latency", 32'(last_valid_cyc - frame_e1 + 1), 32'(LAT));
        check("a5_no_err", 32'(n_err), 32'd0);
        check("a5_held", {24'd0, rx_byte}, 32'hA5);
        check("a5_inactive", {31'd0, rx_active}, 32'd0);

        // False start shorter than half a bit
        rx_data_in = 1'b0;
        repeat (30) @(negedge clk);
        check("false_active", {31'd0, rx_active}, 32'd1);
        idle(H + 20);
        check("false_idle", {31'd0, rx_active}, 32'd0);
        check("false_valid", 32'(n_valid), 32'd1);
        check("false_err", 32'(n_err), 32'd0);
        idle(C);

        // Good 0x11, then 0x3C with a low stop bit
        push_good(8'h11);
        send_frame(8'h11, 1'b1, C);
        idle(C);
        exp_err++;
        send_frame(8'h3C, 1'b0, C);
        idle(2 * C);
        check("ferr_count", 32'(n_err), 32'(exp_err));
        check("ferr_valid", 32'(n_valid), 32'(exp_valid));
        check("ferr_byte_held", {24'd0, rx_byte}, 32'h11);

        // Back-to-back with opposite baud skews
        push_good(8'h00);
        push_good(8'hFF);
        send_frame(8'h00, 1'b1, C + 2);
        send_frame(8'hFF, 1'b1, C - 2);
        idle(2 * C);
        check("b2b_count", 32'(n_valid), 32'(exp_valid));
        check("b2b_last", {24'd0, rx_byte}, 32'hFF);

        // Reset during data bit 4 of 0x5A
        f = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_data_in = f[i];
            repeat (C) @(negedge clk);
        end
        rx_data_in = f[5];
        repeat (H) @(negedge clk);
        rst        = 1'b1;
        rx_data_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte",   {24'd0, rx_byte}, 32'd0);
        check("rst_valid",  {31'd0, rx_valid}, 32'd0);
        check("rst_active", {31'd0, rx_active}, 32'd0);
        check("rst_err",    {31'd0, rx_frame_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_idle", {31'd0, rx_active}, 32'd0);
        last_good = 8'h00;
        idle(C);
        push_good(8'hC3);
        send_frame(8'hC3, 1'b1, C);
        idle(2 * C);
        check("c3_count", 32'(n_valid), 32'(exp_valid));
        check("c3_byte", {24'd0, rx_byte}, 32'hC3);
        check("c3_err", 32'(n_err), 32'(exp_err));

        // Randomized frames: random data, skew, gaps and occasional bad stop bits
        for (int k = 0; k < 40; k++) begin
            b      = 8'($urandom_range(0, 255));
            is_bad = ($urandom_range(0, 7) == 0);
            if (is_bad) begin
                clks = $urandom_range(C - 2, C);
                gap  = 2 * C;
                exp_err++;
            end else begin
                clks = $urandom_range(C - 2, C + 2);
                gap  = $urandom_range(0, 20);
                push_good(b);
            end
            send_frame(b, ~is_bad, clks);
            idle(gap);
            if (is_bad) begin
                check("rand_err_byte_held", {24'd0, rx_byte}, {24'd0, last_good});
            end
        end
        idle(2 * C);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted glitch at every bit centre must be voted out
        push_good(8'h96);
        f = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_data_in = f[i];
            repeat (H) @(negedge clk);
            rx_data_in = ~f[i];
            @(negedge clk);
            rx_data_in = f[i];
            repeat (C - H - 1) @(negedge clk);
        end
        idle(2 * C);
        check("glitch_byte", {24'd0, rx_byte}, 32'h96);
`endif

        check("final_valid", 32'(n_valid), 32'(exp_valid));
        check("final_err", 32'(n_err), 32'(exp_err));
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_idle", {31'd0, rx_active}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
